pipelined_segment_adder: RTL and testbench



---
 rtl/psa_pkg.sv | 35 +++
 rtl/psa_segment.sv | 21 ++
 rtl/pipelined_segment_adder.sv | 173 +++++++++++++++++
 tb/tb_pipelined_segment_adder.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/psa_pkg.sv
// Shared definitions for pipelined_segment_adder.
//
// Provides the segment geometry helpers used to size the pipeline and to
// place each segment's slice of the operands:
//   psa_nseg   - number of segments / pipeline stages, ceil(wa / seg_w)
//   psa_seg_lo - bit offset of segment k within the WA-bit sum
//   psa_seg_w  - width of segment k (the last one may be narrower)
//   psa_seg_hi - one past the top bit of segment k

package psa_pkg;

    function automatic int unsigned psa_nseg(input int unsigned wa, input int unsigned seg_w);
        return (wa + seg_w - 1) / seg_w;
    endfunction

    function automatic int unsigned psa_seg_lo(input int unsigned k, input int unsigned seg_w);
        return k * seg_w;
    endfunction

    function automatic int unsigned psa_seg_w(input int unsigned k, input int unsigned wa,
                                              input int unsigned seg_w);
        int unsigned lo;
        lo = k * seg_w;
        if (wa - lo < seg_w) begin
            return wa - lo;
        end
        return seg_w;
    endfunction

    function automatic int unsigned psa_seg_hi(input int unsigned k, input int unsigned wa,
                                               input int unsigned seg_w);
        return psa_seg_lo(k, seg_w) + psa_seg_w(k, wa, seg_w);
    endfunction

endpackage

// File: rtl/psa_segment.sv
// Combinational slice adder for one carry-chain segment.
//
// Ports:
//   a_i, b_i  W-bit operand slices
//   cin_i     carry into the slice
//   sum_o     W-bit slice sum
//   cout_o    carry out of the slice

module psa_segment #(
    parameter int unsigned W = 13
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         cin_i,
    output logic [W-1:0] sum_o,
    output logic         cout_o
);

    assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{W{1'b0}}, cin_i};

endmodule

// File: rtl/pipelined_segment_adder.sv
// Pipelined WA + zext(WB) adder with the carry chain split into SEG_W-bit
// segments, one segment resolved per pipeline stage. Each stage holds a
// valid bit, the carry into the next segment, the sum bits finished so far
// and the still-unconsumed upper bits of both operands. Full valid/ready
// handshake on both sides; bubbles compress and a full pipeline can accept
// and deliver in the same cycle, so throughput is one result per cycle.
//
// Ports:
//   clk, rst     clock (rising edge), asynchronous active-high reset
//   in_valid     operands presented
//   in_ready     operands accepted this cycle (depends only on the valid
//                chain and out_ready, never on in_a/in_b)
//   in_a, in_b   WA-bit and WB-bit operands, in_b zero-extended to WA
//   in_sub       (PSA_SUBTRACT_EN only) compute A - zext(B); out_sum[WA] is
//                then the raw carry-out, 1 iff A >= zext(B)
//   out_valid    out_sum holds a result
//   out_ready    consumer takes out_sum
//   out_sum      {carry_out, A + zext(B)}, WA+1 bits
//
// Build option: define PSA_SUBTRACT_EN to add the in_sub port.

module pipelined_segment_adder
    import psa_pkg::*;
#(
    parameter int unsigned WA    = 52,
    parameter int unsigned WB    = 29,
    parameter int unsigned SEG_W = 13
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [WA-1:0] in_a,
    input  logic [WB-1:0] in_b,
`ifdef PSA_SUBTRACT_EN
    input  logic          in_sub,
`endif
    output logic          out_valid,
    input  logic          out_ready,
    output logic [WA:0]   out_sum
);

    localparam int unsigned NSEG = psa_nseg(WA, SEG_W);

    typedef logic [NSEG-1:0] stage_vld_t;
    typedef logic [WA-1:0]   word_t;

    // Stage state
    stage_vld_t vld_q;
    stage_vld_t vld_d;
    stage_vld_t carry_q;
    word_t      a_q   [NSEG];
    word_t      b_q   [NSEG];
    word_t      sum_q [NSEG];

    // Handshake
    stage_vld_t load;
    stage_vld_t src_vld;

    // Next-state data per stage, produced by the segment generate loop
    stage_vld_t nxt_carry;
    word_t      nxt_a   [NSEG];
    word_t      nxt_b   [NSEG];
    word_t      nxt_sum [NSEG];

    // Stage 0 operands. Subtraction folds into stage 0 as ~B with carry-in 1;
    // from then on the mode lives entirely in the piped carry and B bits.
    word_t b_ext;
    logic  cin0;

`ifdef PSA_SUBTRACT_EN
    assign b_ext = in_sub ? ~word_t'(in_b) : word_t'(in_b);
    assign cin0  = in_sub;
`else
    assign b_ext = word_t'(in_b);
    assign cin0  = 1'b0;
`endif

    // A stage loads when it is empty or its content moves on this cycle.
    // The chain runs from the output back to the input.
    always_comb begin
        load    = '0;
        src_vld = '0;
        vld_d   = vld_q;

        load[NSEG-1] = ~vld_q[NSEG-1] | out_ready;
        for (int k = int'(NSEG) - 2; k >= 0; k--) begin
            load[k] = ~vld_q[k] | load[k+1];
        end

        src_vld[0] = in_valid;
        for (int k = 1; k < int'(NSEG); k++) begin
            src_vld[k] = vld_q[k-1];
        end

        for (int k = 0; k < int'(NSEG); k++) begin
            if (load[k]) begin
                vld_d[k] = src_vld[k];
            end
        end
    end

    assign in_ready  = load[0];
    assign out_valid = vld_q[NSEG-1];
    assign out_sum   = {carry_q[NSEG-1], sum_q[NSEG-1]};

    for (genvar k = 0; k < NSEG; k++) begin : g_seg
        localparam int unsigned LO = psa_seg_lo(k, SEG_W);
        localparam int unsigned W  = psa_seg_w(k, WA, SEG_W);
        localparam int unsigned HI = psa_seg_hi(k, WA, SEG_W);
        // Bits at and below this segment are consumed and need not travel on.
        localparam word_t LOW_MASK = (word_t'(1) << HI) - word_t'(1);

        word_t        src_a;
        word_t        src_b;
        word_t        src_sum;
        logic         src_c;
        logic [W-1:0] seg_s;
        logic         seg_c;

        if (k == 0) begin : g_first
            assign src_a   = in_a;
            assign src_b   = b_ext;
            assign src_sum = '0;
            assign src_c   = cin0;
        end else begin : g_next
            assign src_a   = a_q[k-1];
            assign src_b   = b_q[k-1];
            assign src_sum = sum_q[k-1];
            assign src_c   = carry_q[k-1];
        end

        psa_segment #(
            .W (W)
        ) u_seg (
            .a_i    (src_a[LO +: W]),
            .b_i    (src_b[LO +: W]),
            .cin_i  (src_c),
            .sum_o  (seg_s),
            .cout_o (seg_c)
        );

        // src_sum is zero from LO upward, so OR-ing places the new segment.
        assign nxt_sum[k]   = src_sum | (word_t'(seg_s) << LO);
        assign nxt_a[k]     = src_a & ~LOW_MASK;
        assign nxt_b[k]     = src_b & ~LOW_MASK;
        assign nxt_carry[k] = seg_c;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q   <= '0;
            carry_q <= '0;
            for (int k = 0; k < int'(NSEG); k++) begin
                a_q[k]   <= '0;
                b_q[k]   <= '0;
                sum_q[k] <= '0;
            end
        end else begin
            vld_q <= vld_d;
            for (int k = 0; k < int'(NSEG); k++) begin
                // Data only moves with a real item; a stalled stage holds.
                if (load[k] && src_vld[k]) begin
                    a_q[k]     <= nxt_a[k];
                    b_q[k]     <= nxt_b[k];
                    sum_q[k]   <= nxt_sum[k];
                    carry_q[k] <= nxt_carry[k];
                end
            end
        end
    end

endmodule

// File: tb/tb_pipelined_segment_adder.sv
// Self-checking bench for pipelined_segment_adder: directed vectors with
// hand-computed sums, streaming, back-pressure, mid-flight reset and two
// narrow configurations (WA=8 with SEG_W=3 and SEG_W=16).

module tb_pipelined_segment_adder;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    // Default configuration DUT
    logic        in_valid  = 1'b0;
    logic        in_ready;
    logic [51:0] in_a      = '0;
    logic [28:0] in_b      = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [52:0] out_sum;
`ifdef PSA_SUBTRACT_EN
    logic        in_sub    = 1'b0;
`endif

    // Narrow configurations, driven with identical inputs
    logic       s_valid = 1'b0;
    logic [7:0] s_a     = '0;
    logic [7:0] s_b     = '0;
    logic       s_ordy  = 1'b0;
    logic       s3_in_ready, s3_out_valid;
    logic [8:0] s3_out_sum;
    logic       s16_in_ready, s16_out_valid;
    logic [8:0] s16_out_sum;

    pipelined_segment_adder u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
`ifdef PSA_SUBTRACT_EN
        .in_sub    (in_sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum)
    );

    pipelined_segment_adder #(.WA(8), .WB(8), .SEG_W(3)) u_seg3 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (s_valid),
        .in_ready  (s3_in_ready),
        .in_a      (s_a),
        .in_b      (s_b),
`ifdef PSA_SUBTRACT_EN
        .in_sub    (1'b0),
`endif
        .out_valid (s3_out_valid),
        .out_ready (s_ordy),
        .out_sum   (s3_out_sum)
    );

    pipelined_segment_adder #(.WA(8), .WB(8), .SEG_W(16)) u_seg16 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (s_valid),
        .in_ready  (s16_in_ready),
        .in_a      (s_a),
        .in_b      (s_b),
`ifdef PSA_SUBTRACT_EN
        .in_sub    (1'b0),
`endif
        .out_valid (s16_out_valid),
        .out_ready (s_ordy),
        .out_sum   (s16_out_sum)
    );

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Hand-computed vectors: A, B, {carry, sum}
    logic [51:0] va [8];
    logic [28:0] vb [8];
    logic [52:0] vs [8];
    logic [52:0] exp_q [$];

    // Drive main DUT inputs at the falling edge, then observe just after.
    task automatic step(input logic v, input logic [51:0] a, input logic [28:0] b,
                        input logic ordy, output logic acc, output logic dlv,
                        output logic [52:0] sum);
        @(negedge clk);
        in_valid  = v;
        in_a      = a;
        in_b      = b;
        out_ready = ordy;
        #1;
        acc = in_valid && in_ready;
        dlv = out_valid && out_ready;
        sum = out_sum;
    endtask

    // One isolated operation: accept, measure latency, check the single pulse.
    task automatic single(input string tag, input logic [51:0] a, input logic [28:0] b,
                          input logic [52:0] exp);
        logic acc, dlv;
        logic [52:0] sum;
        int lat;
        lat = 0;
        step(1'b1, a, b, 1'b1, acc, dlv, sum);
        check({tag, "_accept"}, 64'(acc), 64'd1);
        for (int n = 1; n <= 20; n++) begin
            step(1'b0, a, b, 1'b1, acc, dlv, sum);
            if (dlv) begin
                lat = n;
                break;
            end
        end
        check({tag, "_latency"}, 64'(lat), 64'd4);
        check({tag, "_sum"}, 64'(sum), 64'(exp));
        step(1'b0, a, b, 1'b1, acc, dlv, sum);
        check({tag, "_one_pulse"}, 64'(out_valid), 64'd0);
    endtask

    task automatic small_run(input string tag, input logic [7:0] a, input logic [7:0] b,
                             input logic [8:0] exp);
        int lat3, lat16;
        logic [8:0] sum3, sum16;
        lat3  = 0;
        lat16 = 0;
        sum3  = '0;
        sum16 = '0;
        @(negedge clk);
        s_valid = 1'b1;
        s_a     = a;
        s_b     = b;
        s_ordy  = 1'b1;
        #1;
        check({tag, "_ready"}, 64'(s3_in_ready && s16_in_ready), 64'd1);
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            s_valid = 1'b0;
            #1;
            if (s3_out_valid && lat3 == 0) begin
                lat3 = n;
                sum3 = s3_out_sum;
            end
            if (s16_out_valid && lat16 == 0) begin
                lat16 = n;
                sum16 = s16_out_sum;
            end
        end
        check({tag, "_seg3_latency"}, 64'(lat3), 64'd3);
        check({tag, "_seg3_sum"}, 64'(sum3), 64'(exp));
        check({tag, "_seg16_latency"}, 64'(lat16), 64'd1);
        check({tag, "_seg16_sum"}, 64'(sum16), 64'(exp));
    endtask

    initial begin
        logic acc, dlv;
        logic [52:0] sum, held;
        int sent, got, stalls, first_d, last_d, idx;
        bit have_held;

        va[0] = 52'hF_FFFF_FFFF_FFFF; vb[0] = 29'h1;         vs[0] = 53'h10_0000_0000_0000;
        va[1] = 52'h0;                vb[1] = 29'h0;         vs[1] = 53'h0;
        va[2] = 52'hF_FFFF_FFFF_FFFF; vb[2] = 29'h1FFF_FFFF; vs[2] = 53'h10_0000_1FFF_FFFE;
        va[3] = 52'h0_0000_0000_1FFF; vb[3] = 29'h1;         vs[3] = 53'h00_0000_0000_2000;
        va[4] = 52'h0_1234_5678_9ABC; vb[4] = 29'h0765_4321; vs[4] = 53'h00_1234_5DDD_DDDD;
        va[5] = 52'h8_0000_0000_0000; vb[5] = 29'h0;         vs[5] = 53'h08_0000_0000_0000;
        va[6] = 52'hA_AAAA_AAAA_AAAA; vb[6] = 29'h1555_5555; vs[6] = 53'h0A_AAAA_BFFF_FFFF;
        va[7] = 52'h0_0000_03FF_FFFF; vb[7] = 29'h1;         vs[7] = 53'h00_0000_0400_0000;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_out_sum", 64'(out_sum), 64'd0);
        rst = 1'b0;
        #1;
        check("reset_in_ready", 64'(in_ready), 64'd1);

        // Full carry ripple through all four segments
        single("ripple", va[0], vb[0], vs[0]);

        // Back-to-back stream of 16 items
        exp_q.delete();
        sent = 0; got = 0; stalls = 0; first_d = -1; last_d = -1;
        for (int n = 0; n < 80 && got < 16; n++) begin
            idx = sent % 8;
            step(sent < 16, va[idx], vb[idx], 1'b1, acc, dlv, sum);
            if (in_valid && !acc) stalls++;
            if (acc) begin
                exp_q.push_back(vs[idx]);
                sent++;
            end
            if (dlv) begin
                if (first_d < 0) first_d = n;
                last_d = n;
                if (exp_q.size() == 0) begin
                    check("stream_extra", 64'(sum), 64'd0);
                end else begin
                    check($sformatf("stream_sum%0d", got), 64'(sum), 64'(exp_q.pop_front()));
                end
                got++;
            end
        end
        check("stream_stalls", 64'(stalls), 64'd0);
        check("stream_count", 64'(got), 64'd16);
        check("stream_consecutive", 64'(last_d - first_d + 1), 64'd16);

        // Back-pressure: fill with out_ready low, then drain
        exp_q.delete();
        sent = 0;
        have_held = 1'b0;
        held = '0;
        for (int n = 0; n < 8; n++) begin
            idx = (n + 2) % 8;
            step(1'b1, va[idx], vb[idx], 1'b0, acc, dlv, sum);
            if (acc) begin
                exp_q.push_back(vs[idx]);
                sent++;
            end
            if (out_valid) begin
                if (!have_held) begin
                    held = sum;
                    have_held = 1'b1;
                end else begin
                    check("bp_hold_sum", 64'(sum), 64'(held));
                end
            end
        end
        check("bp_accepts", 64'(sent), 64'd4);
        check("bp_in_ready_low", 64'(in_ready), 64'd0);
        check("bp_out_valid", 64'(out_valid), 64'd1);
        check("bp_held_first", 64'(held), 64'(vs[2]));
        got = 0;
        for (int n = 0; n < 12; n++) begin
            step(1'b0, va[0], vb[0], 1'b1, acc, dlv, sum);
            if (dlv) begin
                if (exp_q.size() == 0) begin
                    check("bp_duplicate", 64'(sum), 64'd0);
                end else begin
                    check($sformatf("bp_drain%0d", got), 64'(sum), 64'(exp_q.pop_front()));
                end
                got++;
            end
        end
        check("bp_drain_count", 64'(got), 64'd4);

        // Asynchronous reset with three items in flight
        sent = 0;
        for (int n = 0; n < 20; n++) begin
            step(sent < 3, va[4 + (sent % 3)], vb[4 + (sent % 3)], 1'b0, acc, dlv, sum);
            if (acc) sent++;
            if (sent == 3 && out_valid) break;
        end
        check("prereset_accepts", 64'(sent), 64'd3);
        check("prereset_valid", 64'(out_valid), 64'd1);
        rst = 1'b1;
        #1;
        check("async_rst_valid", 64'(out_valid), 64'd0);
        check("async_rst_sum", 64'(out_sum), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 64'(in_ready), 64'd1);
        got = 0;
        for (int n = 0; n < 10; n++) begin
            step(1'b0, va[0], vb[0], 1'b1, acc, dlv, sum);
            if (dlv) got++;
        end
        check("post_rst_no_stale", 64'(got), 64'd0);

        // Narrow configurations: NSEG=3 (last segment 2 bits) and NSEG=1
        small_run("ff_ff", 8'hFF, 8'hFF, 9'h1FE);
        small_run("2d_1c", 8'h2D, 8'h1C, 9'h049);

`ifdef PSA_SUBTRACT_EN
        in_sub = 1'b1;
        single("sub_100_30", 52'd100, 29'd30, 53'h10_0000_0000_0046);
        single("sub_5_9", 52'd5, 29'd9, 53'h0F_FFFF_FFFF_FFFC);
        in_sub = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
